// File: rtl/multicycle_alu.sv
// multicycle_alu: parametrised ALU with a valid/ready handshake.
// Ops 0-10 finish in one cycle. Multiply is a radix-2 shift-add iteration
// that takes WIDTH cycles. Unsigned divide/remainder is a restoring
// division of the same length, and it is built only when the macro
// MULTICYCLE_ALU_DIV_EN is defined. Without that macro, ops 13/14 return 0.
// Reset is synchronous and active-high.
module multicycle_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [3:0]       io_alu_op,
   input  logic [WIDTH-1:0] io_in_a,
   input  logic [WIDTH-1:0] io_in_b,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [WIDTH-1:0] io_out,
   output logic             io_zero
);

   localparam int SHAMT_W = $clog2(WIDTH);
   localparam logic [SHAMT_W:0] LAST_COUNT = (SHAMT_W + 1)'(WIDTH - 1);

   localparam logic [3:0] OP_AND   = 4'd0;
   localparam logic [3:0] OP_OR    = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_XOR   = 4'd3;
   localparam logic [3:0] OP_NOR   = 4'd4;
   localparam logic [3:0] OP_SRL   = 4'd5;
   localparam logic [3:0] OP_SUB   = 4'd6;
   localparam logic [3:0] OP_SLTU  = 4'd7;
   localparam logic [3:0] OP_SLL   = 4'd8;
   localparam logic [3:0] OP_SRA   = 4'd9;
   localparam logic [3:0] OP_SLT   = 4'd10;
   localparam logic [3:0] OP_MULLO = 4'd11;
   localparam logic [3:0] OP_MULHU = 4'd12;
   localparam logic [3:0] OP_DIVU  = 4'd13;
   localparam logic [3:0] OP_REMU  = 4'd14;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t               state;
   logic [SHAMT_W:0]     count;
   logic [3:0]           op_q;
   logic [WIDTH-1:0]     operand_q;
   logic [2*WIDTH-1:0]   acc;

   logic [SHAMT_W-1:0]   shamt;
   logic [WIDTH-1:0]     quick_result;
   logic                 start_long;
   logic                 is_mul_op;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [2*WIDTH-1:0]   iter_next;
   logic [WIDTH-1:0]     long_result;

   assign io_in_ready  = (state == IDLE);
   assign io_out_valid = (state == DONE);
   assign io_zero      = (io_out == '0);

   assign shamt     = io_in_b[SHAMT_W-1:0];
   assign is_mul_op = (io_alu_op == OP_MULLO) || (io_alu_op == OP_MULHU);

   // One multiply step: conditionally add A into the upper half, then shift the pair right.
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand_q} : '0);
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

`ifdef MULTICYCLE_ALU_DIV_EN
   logic [WIDTH:0]       div_diff;
   logic [2*WIDTH-1:0]   div_next;

   // One restoring-division step: the upper half holds the partial remainder and the lower half shifts the dividend out and the quotient in.
   assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand_q};
   assign div_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
`endif

   // Single-cycle results, and the decision whether the op needs the iterative engine.
   always_comb begin
      quick_result = '0;
      start_long   = 1'b0;
      case (io_alu_op)
         OP_AND:   quick_result = io_in_a & io_in_b;
         OP_OR:    quick_result = io_in_a | io_in_b;
         OP_ADD:   quick_result = io_in_a + io_in_b;
         OP_XOR:   quick_result = io_in_a ^ io_in_b;
         OP_NOR:   quick_result = ~(io_in_a | io_in_b);
         OP_SRL:   quick_result = io_in_a >> shamt;
         OP_SUB:   quick_result = io_in_a - io_in_b;
         OP_SLTU:  quick_result = {{(WIDTH-1){1'b0}}, (io_in_a < io_in_b)};
         OP_SLL:   quick_result = io_in_a << shamt;
         OP_SRA:   quick_result = $unsigned($signed(io_in_a) >>> shamt);
         OP_SLT:   quick_result = {{(WIDTH-1){1'b0}}, ($signed(io_in_a) < $signed(io_in_b))};
         OP_MULLO,
         OP_MULHU: start_long = 1'b1;
`ifdef MULTICYCLE_ALU_DIV_EN
         OP_DIVU: begin
            if (io_in_b == '0) quick_result = '1;
            else               start_long   = 1'b1;
         end
         OP_REMU: begin
            if (io_in_b == '0) quick_result = io_in_a;
            else               start_long   = 1'b1;
         end
`endif
         default:  quick_result = '0;
      endcase
   end

   // Choose the engine step for the latched op and pick the final half of the accumulator.
   always_comb begin
      iter_next = mul_next;
`ifdef MULTICYCLE_ALU_DIV_EN
      if ((op_q == OP_DIVU) || (op_q == OP_REMU)) iter_next = div_next;
`endif
      if ((op_q == OP_MULLO) || (op_q == OP_DIVU)) long_result = iter_next[WIDTH-1:0];
      else                                          long_result = iter_next[2*WIDTH-1:WIDTH];
   end

   // Handshake FSM: accept in IDLE, iterate in BUSY, and hold the result in DONE until it is consumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         op_q      <= '0;
         operand_q <= '0;
         acc       <= '0;
         io_out    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (io_in_valid) begin
                  op_q  <= io_alu_op;
                  count <= '0;
                  if (start_long) begin
                     state <= BUSY;
                     if (is_mul_op) begin
                        acc       <= {{WIDTH{1'b0}}, io_in_b};
                        operand_q <= io_in_a;
                     end else begin
                        acc       <= {{WIDTH{1'b0}}, io_in_a};
                        operand_q <= io_in_b;
                     end
                  end else begin
                     io_out <= quick_result;
                     state  <= DONE;
                  end
               end
            end
            BUSY: begin
               acc   <= iter_next;
               count <= count + 1'b1;
               if (count == LAST_COUNT) begin
                  io_out <= long_result;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (io_out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: scoreboard bench for multicycle_alu with WIDTH=32.
// The driver pushes the expected result and latency from an arithmetic
// reference model. A separate monitor pops those entries and checks them
// whenever io_out_valid is presented.
module tb_multicycle_alu;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         io_in_valid;
   logic         io_in_ready;
   logic [3:0]   io_alu_op;
   logic [W-1:0] io_in_a;
   logic [W-1:0] io_in_b;
   logic         io_out_valid;
   logic         io_out_ready;
   logic [W-1:0] io_out;
   logic         io_zero;

   typedef struct {
      logic [W-1:0] res;
      int           lat;
      int           acc_cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   bit   hold_off = 1'b0;

   multicycle_alu #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .io_in_valid  (io_in_valid),
      .io_in_ready  (io_in_ready),
      .io_alu_op    (io_alu_op),
      .io_in_a      (io_in_a),
      .io_in_b      (io_in_b),
      .io_out_valid (io_out_valid),
      .io_out_ready (io_out_ready),
      .io_out       (io_out),
      .io_zero      (io_zero)
   );

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model derived from the op-code definitions with plain arithmetic.
   function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] p;
      logic [W-1:0]   r;
      int             sh;
      sh = int'(b % W);
      p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      r  = '0;
      case (op)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  r = a + b;
         4'd3:  r = a ^ b;
         4'd4:  r = ~(a | b);
         4'd5:  r = a >> sh;
         4'd6:  r = a - b;
         4'd7:  r[0] = (a < b);
         4'd8:  r = a << sh;
         4'd9:  r = (a >> sh) | (a[W-1] ? ~({W{1'b1}} >> sh) : '0);
         4'd10: r[0] = (a[W-1] != b[W-1]) ? a[W-1] : (a < b);
         4'd11: r = p[W-1:0];
         4'd12: r = p[2*W-1:W];
`ifdef MULTICYCLE_ALU_DIV_EN
         4'd13: r = (b == '0) ? '1 : a / b;
         4'd14: r = (b == '0) ? a : a % b;
`endif
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic int expLatency(input logic [3:0] op, input logic [W-1:0] b);
      if (op == 4'd11 || op == 4'd12) return W + 1;
`ifdef MULTICYCLE_ALU_DIV_EN
      if ((op == 4'd13 || op == 4'd14) && b != '0) return W + 1;
`endif
      return 1;
   endfunction

   task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: pops one expectation per presented result and checks the value, flag, latency, hold and release.
   initial begin
      exp_t cur;
      bit   seen;
      bit   expect_idle;
      int   lat;
      seen        = 1'b0;
      expect_idle = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            seen        = 1'b0;
            expect_idle = 1'b0;
         end else begin
            if (expect_idle) begin
               checkOutput("ready_after_consume", W'(io_in_ready), W'(1));
               checkOutput("valid_after_consume", W'(io_out_valid), W'(0));
               expect_idle = 1'b0;
            end
            if (io_out_valid) begin
               if (!seen) begin
                  if (sb.size() == 0) begin
                     vectors++;
                     miscompares++;
                     $display("[TB] FAIL unexpected_result: got 0x%0h, required no result (cycle %0d)", io_out, cyc);
                  end else begin
                     cur  = sb.pop_front();
                     seen = 1'b1;
                     lat  = cyc - cur.acc_cyc + 1;
                     checkOutput("latency", W'(lat), W'(cur.lat));
                     checkOutput("result", io_out, cur.res);
                     checkOutput("zero_flag", W'(io_zero), W'(cur.res == '0));
                  end
               end else begin
                  checkOutput("hold_stable", io_out, cur.res);
               end
               checkOutput("ready_low_while_valid", W'(io_in_ready), W'(0));
               if (io_out_ready) begin
                  seen        = 1'b0;
                  expect_idle = 1'b1;
               end
            end
         end
      end
   end

   // Drive after each rising edge. Consumer readiness is random unless held off.
   task automatic nextCycle();
      @(posedge clk);
      #2;
      io_out_ready = hold_off ? 1'b0 : ($urandom_range(0, 3) != 0);
   endtask

   task automatic garbageOrIdle();
      if (io_in_ready) begin
         io_in_valid = 1'b0;
      end else begin
         io_in_valid = 1'b1;
         io_alu_op   = 4'($urandom);
         io_in_a     = $urandom;
         io_in_b     = $urandom;
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         nextCycle();
         garbageOrIdle();
      end
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   waited;
      waited = 0;
      nextCycle();
      while (!io_in_ready && waited < 200) begin
         garbageOrIdle();
         nextCycle();
         waited++;
      end
      if (!io_in_ready) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL accept_timeout: io_in_ready stayed 0, required 1");
         garbageOrIdle();
      end else begin
         io_in_valid = 1'b1;
         io_alu_op   = op;
         io_in_a     = a;
         io_in_b     = b;
         e.res       = model(op, a, b);
         e.lat       = expLatency(op, b);
         e.acc_cyc   = cyc + 1;
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      nextCycle();
      garbageOrIdle();
      while ((sb.size() != 0 || !io_in_ready) && waited < 2000) begin
         nextCycle();
         garbageOrIdle();
         waited++;
      end
      if (sb.size() != 0 || !io_in_ready) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL drain_timeout: %0d results pending, required 0", sb.size());
      end
   endtask

   // Watchdog so the bench always terminates.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      reset        = 1'b1;
      io_in_valid  = 1'b0;
      io_alu_op    = '0;
      io_in_a      = '0;
      io_in_b      = '0;
      io_out_ready = 1'b0;
      $display("[TB] multicycle_alu scoreboard bench, WIDTH=%0d", W);
      repeat (3) nextCycle();
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset_ready", W'(io_in_ready), W'(1));
      checkOutput("reset_valid", W'(io_out_valid), W'(0));
      checkOutput("reset_out", io_out, '0);
      checkOutput("reset_zero", W'(io_zero), W'(1));

      // Legacy ops and the zero flag.
      applyStimulus(4'd0, 32'h0000F0F0, 32'h00000FF0);
      applyStimulus(4'd4, 32'h0000F0F0, 32'h00000FF0);
      applyStimulus(4'd6, 32'h0000F0F0, 32'h00000FF0);
      applyStimulus(4'd2, 32'h0000F0F0, 32'h00000FF0);
      applyStimulus(4'd6, 32'd5, 32'd5);
      // Shifts and compares.
      applyStimulus(4'd9, 32'h80000000, 32'd4);
      applyStimulus(4'd5, 32'h80000000, 32'd4);
      applyStimulus(4'd8, 32'd1, 32'h25);
      applyStimulus(4'd10, 32'hFFFFFFFF, 32'd1);
      applyStimulus(4'd7, 32'hFFFFFFFF, 32'd1);
      applyStimulus(4'd15, 32'h12345678, 32'h9);
      // Multiply and divide, including division by zero.
      applyStimulus(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF);
      applyStimulus(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF);
      applyStimulus(4'd13, 32'd100, 32'd7);
      applyStimulus(4'd14, 32'd100, 32'd7);
      applyStimulus(4'd13, 32'd9, 32'd0);
      applyStimulus(4'd14, 32'd9, 32'd0);
      drain();

      // Backpressure: hold the consumer off while garbage requests are presented.
      hold_off = 1'b1;
      idleCycles(1);
      applyStimulus(4'd2, 32'hFFFFFFFF, 32'd3);
      idleCycles(6);
      hold_off     = 1'b0;
      io_out_ready = 1'b1;
      idleCycles(3);
      drain();

      // Reset in the middle of a multiply: no result may ever appear.
      applyStimulus(4'd11, $urandom, $urandom);
      idleCycles(9);
      reset = 1'b1;
      sb.delete();
      nextCycle();
      reset       = 1'b0;
      io_in_valid = 1'b0;
      @(negedge clk);
      checkOutput("abort_ready", W'(io_in_ready), W'(1));
      checkOutput("abort_valid", W'(io_out_valid), W'(0));
      checkOutput("abort_out", io_out, '0);
      checkOutput("abort_zero", W'(io_zero), W'(1));
      idleCycles(W + 10);

      // Randomized mix of every op.
      for (int i = 0; i < 80; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         case ($urandom_range(0, 3))
            0:       b = W'($urandom_range(0, 3));
            1:       b = a;
            default: b = $urandom;
         endcase
         applyStimulus(op, a, b);
      end
      drain();
      idleCycles(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
